// File: rtl/regfile_pkg.sv
// Shared sizing constants for the OpenMIPS32 architectural register file.
// Mirrors the core's RegBus / RegAddrBus / RegNum / RegNumLog2 / ZeroWord definitions.
package regfile_pkg;

    localparam int REG_BUS_W    = 32;  // RegBus width
    localparam int REG_ADDR_W   = 5;   // RegAddrBus width / RegNumLog2
    localparam int REG_NUM      = 32;  // RegNum

    localparam logic [REG_BUS_W-1:0]  ZERO_WORD    = '0;
    localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = '0;

endpackage : regfile_pkg

// File: rtl/regfile_rport.sv
// One combinational read port: reset, zero register, write-first bypass, then array.
// Instantiated once per decode read request so both ports match by construction.
module regfile_rport #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              rst,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] array_data,
    output logic [DATA_W-1:0] rdata
);

    // Priority order matters: register 0 must read zero even when a write to it is in flight.
    always_comb begin
        rdata = '0;
        if (rst) begin
            rdata = '0;
        end else if (raddr == '0) begin
            rdata = '0;
        end else if (re && we && (waddr == raddr)) begin
            rdata = wdata;
        end else if (re) begin
            rdata = array_data;
        end
    end

endmodule : regfile_rport

// File: rtl/regfile.sv
// OpenMIPS32 general-purpose register file: 32 x 32, two async read ports, one sync write port.
// No handshake: the file is always ready; reads are zero-latency and the caller owns hazards.
module regfile
    import regfile_pkg::*;
#(
    parameter int DATA_W   = REG_BUS_W,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int NUM_REGS = REG_NUM      // must equal 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2
);

    // Register 0 has no storage; the array starts at index 1.
    logic [DATA_W-1:0] mem [1:NUM_REGS-1];
    logic [DATA_W-1:0] array_data1;
    logic [DATA_W-1:0] array_data2;

    // Address compare per entry keeps an unknown waddr from touching state when we=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (waddr == ADDR_W'(i)) begin
                    mem[i] <= wdata;
                end
            end
        end
    end

    always_comb begin
        array_data1 = '0;
        array_data2 = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (raddr1 == ADDR_W'(i)) begin
                array_data1 = mem[i];
            end
            if (raddr2 == ADDR_W'(i)) begin
                array_data2 = mem[i];
            end
        end
    end

    regfile_rport #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rport1 (
        .rst        (rst),
        .re         (re1),
        .raddr      (raddr1),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .array_data (array_data1),
        .rdata      (rdata1)
    );

    regfile_rport #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rport2 (
        .rst        (rst),
        .re         (re2),
        .raddr      (raddr2),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .array_data (array_data2),
        .rdata      (rdata2)
    );

endmodule : regfile

// File: doc/regfile.md
Name: regfile

Overview:
- Architectural general-purpose register file of the OpenMIPS32 core: 32 x 32-bit registers.
- Acts as the responder to the decode stage's two register-read requests, and as the sink of the write-back stage's single write port.
- Two asynchronous read ports and one synchronous write port.
- Write-first bypass: a value being written back in the current cycle is visible to decode in the same cycle, closing the three-stage forwarding gap that the EX/MEM forwarding paths do not cover.

Parameters:
- DATA_W, 32, register and data width (matches `RegBus).
- ADDR_W, 5, register address width (matches `RegAddrBus).
- NUM_REGS, 32, number of architectural registers; must equal 2**ADDR_W.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high (`RstEnable = 1'b1).
- we  in  1  write enable from write-back stage (`WriteEnable = 1).
- waddr  in  ADDR_W  write register address.
- wdata  in  DATA_W  write data.
- re1  in  1  read enable, port 1 (`ReadEnable = 1).
- raddr1  in  ADDR_W  read address, port 1.
- rdata1  out  DATA_W  read data, port 1.
- re2  in  1  read enable, port 2.
- raddr2  in  ADDR_W  read address, port 2.
- rdata2  out  DATA_W  read data, port 2.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Storage: registers 1..31 are flops; register 0 has no storage.
- Reset, storage:
  - At a rising edge with rst=1, registers 1..31 all become `ZeroWord.
  - Any write presented in that cycle is discarded.
- Reset, outputs: while rst=1, rdata1 and rdata2 are `ZeroWord (combinational, independent of the edge).
- Write:
  - At a rising edge with rst=0, we=1 and waddr!=0: reg[waddr] <= wdata.
  - Writes with waddr=0 are ignored.
  - No other register changes.
- Read, per port n, combinational, zero latency, priority in this order:
  1. rst=1 -> 0.
  2. raddrn=0 -> 0, including when a write to register 0 is pending.
  3. ren=1 and we=1 and waddr==raddrn -> wdata (bypass).
  4. ren=1 -> reg[raddrn].
  5. ren=0 -> 0.
- Ports are fully independent:
  - Both may read the same address simultaneously.
  - Both may hit the bypass simultaneously.
- Bypass is purely combinational: wdata to rdata with no added register stage. The path from decode to EX must tolerate this.
- Read-then-write ordering: a read in cycle N with no matching write returns the pre-edge value. The write committed at the end of cycle N is seen from cycle N+1 onward.
- Reset mid-operation:
  - If rst rises while we=1, the write is lost and all registers clear at that edge.
  - The first cycle with rst=0 reads zeros unless bypassed.
- X-safety:
  - Unknown waddr with we=0 must not corrupt state.
  - we=0 cycles leave all storage unchanged.
- No stall or handshake: the register file is always ready; the caller owns hazard handling.

Decomposition:
- Shared defines header, already included by the core:
  - `RegBus, `RegAddrBus, `RegNum, `RegNumLog2, `ZeroWord.
  - `RstEnable, `WriteEnable, `ReadEnable, `ReadDisable, `NOPRegAddr.
- Add `RegNum (32) and `RegNumLog2 (5) if not already present.
- One natural sub-module, regfile_rport: a single read port containing the priority mux (reset/zero-reg/bypass/array). Instantiate it twice so both ports are identical by construction.
- The write port and the storage array stay in regfile.

Test Plan:
- Reset clear: preload r5=0xDEADBEEF; assert rst for 1 cycle with we=1, waddr=5, wdata=0x12345678 -> after the edge, re1=1/raddr1=5 gives 0x00000000; during rst, rdata1=rdata2=0.
- Basic write/read: cycle 0 we=1, waddr=3, wdata=0x0000_1234 -> in cycle 1 (we=0), re1=1/raddr1=3 gives 0x00001234; re2=1/raddr2=4 gives 0.
- Bypass both ports: r7=0x1111_1111 stored; in the same cycle we=1, waddr=7, wdata=0x2222_2222, re1=re2=1, raddr1=raddr2=7 -> both rdata=0x22222222 combinationally; next cycle without a write both read 0x22222222.
- Register zero: we=1, waddr=0, wdata=0xFFFF_FFFF with re1=1/raddr1=0 -> rdata1=0 in the same cycle and in every later cycle.
- Read disable: r9=0xA5A5_A5A5 stored; re2=0, raddr2=9 -> rdata2=0; set re2=1 -> 0xA5A5A5A5.
- Back-to-back writes: write r1=1, r1=2, r1=3 on consecutive cycles while reading raddr1=1 every cycle -> rdata1 sequence 1, 2, 3 via bypass, then 3 held; r2..r31 remain 0 after a full sweep read.
